// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe encodings: cell marks, result codes and the win-line table.
// Cell index = row*3 + col; cell i occupies board[2i+1:2i].
package ttt_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        MARK_X = 2'b01,
        MARK_O = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        NONE  = 2'b00,
        X_WIN = 2'b01,
        O_WIN = 2'b10,
        DRAW  = 2'b11
    } winner_t;

    localparam logic [3:0] CURSOR_RESET = 4'd4;
    localparam int         NUM_CELLS    = 9;
    localparam int         NUM_LINES    = 8;

    localparam logic [3:0] WIN_LINES [NUM_LINES][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] idx);
        return b[{idx, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer, stability counter and rising-edge press pulse
// for one raw asynchronous push-button.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 2
) (
    input  logic clk,
    input  logic resetN,
    input  logic button,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic          stable;
    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            stable <= 1'b0;
            count  <= '0;
            press  <= 1'b0;
        end else begin
            sync_a <= button;
            sync_b <= sync_a;
            press  <= 1'b0;
            if (sync_b == stable) begin
                count <= '0;
            end else if (count == LAST) begin
                // Only a 0->1 acceptance is a press; releases are silent.
                stable <= sync_b;
                count  <= '0;
                press  <= sync_b;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/move_controller.sv
// Turns debounced button presses into cursor moves and mark commits, and
// keeps the board, turn and sticky win/draw result.
module move_controller
    import ttt_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        upButton,
    input  logic        downButton,
    input  logic        leftButton,
    input  logic        rightButton,
    input  logic        centerButton,
    output logic [17:0] board,
    output logic [3:0]  cursor,
    output logic        turn,
    output logic        moveValid,
    output logic        moveReject,
    output logic [1:0]  winner,
    output logic        gameOver
);

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_CENTER,
        ACT_UP,
        ACT_DOWN,
        ACT_LEFT,
        ACT_RIGHT
    } action_t;

    logic up_press;
    logic down_press;
    logic left_press;
    logic right_press;
    logic center_press;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
        .clk(clk), .resetN(resetN), .button(upButton), .press(up_press)
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
        .clk(clk), .resetN(resetN), .button(downButton), .press(down_press)
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
        .clk(clk), .resetN(resetN), .button(leftButton), .press(left_press)
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
        .clk(clk), .resetN(resetN), .button(rightButton), .press(right_press)
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_center (
        .clk(clk), .resetN(resetN), .button(centerButton), .press(center_press)
    );

    function automatic logic [3:0] step_cursor(input logic [3:0] cur, input action_t act);
        logic [3:0] row;
        logic [3:0] col;
        row = cur / 4'd3;
        col = cur % 4'd3;
        case (act)
            ACT_UP:    step_cursor = (row == 4'd0) ? cur + 4'd6 : cur - 4'd3;
            ACT_DOWN:  step_cursor = (row == 4'd2) ? cur - 4'd6 : cur + 4'd3;
            ACT_LEFT:  step_cursor = (col == 4'd0) ? cur + 4'd2 : cur - 4'd1;
            ACT_RIGHT: step_cursor = (col == 4'd2) ? cur - 4'd2 : cur + 4'd1;
            default:   step_cursor = cur;
        endcase
    endfunction

    action_t action;

    always_comb begin
        action = ACT_NONE;
        if (center_press)     action = ACT_CENTER;
        else if (up_press)    action = ACT_UP;
        else if (down_press)  action = ACT_DOWN;
        else if (left_press)  action = ACT_LEFT;
        else if (right_press) action = ACT_RIGHT;
    end

    logic [1:0] cur_cell;
    winner_t    line_win;
    winner_t    result;
    logic       full;
    logic [1:0] ca;
    logic [1:0] cb;
    logic [1:0] cc;

    assign cur_cell = cell_at(board, cursor);

    always_comb begin
        line_win = NONE;
        full     = 1'b1;
        ca       = 2'b00;
        cb       = 2'b00;
        cc       = 2'b00;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (board[2*i +: 2] == EMPTY) full = 1'b0;
        end
        for (int l = 0; l < NUM_LINES; l++) begin
            ca = cell_at(board, WIN_LINES[l][0]);
            cb = cell_at(board, WIN_LINES[l][1]);
            cc = cell_at(board, WIN_LINES[l][2]);
            if (ca != EMPTY && ca == cb && ca == cc) line_win = winner_t'(ca);
        end
        if (line_win != NONE) result = line_win;
        else if (full)        result = DRAW;
        else                  result = NONE;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            board      <= '0;
            cursor     <= CURSOR_RESET;
            turn       <= 1'b0;
            moveValid  <= 1'b0;
            moveReject <= 1'b0;
            winner     <= NONE;
            gameOver   <= 1'b0;
        end else begin
            moveValid  <= 1'b0;
            moveReject <= 1'b0;
            if (action == ACT_CENTER) begin
                if (!gameOver && cur_cell == EMPTY) begin
                    board[{cursor, 1'b0} +: 2] <= turn ? MARK_O : MARK_X;
                    turn      <= ~turn;
                    moveValid <= 1'b1;
                end else begin
                    moveReject <= 1'b1;
                end
            end else if (action != ACT_NONE) begin
                cursor <= step_cursor(cursor, action);
            end
            // Result latches once; later board changes cannot alter it.
            if (winner == NONE && result != NONE) begin
                winner   <= result;
                gameOver <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_move_controller.sv
// Scoreboard bench for move_controller: stimulus pushes predicted outcomes,
// an independent monitor pops and compares them when the DUT reacts.
module tb_move_controller;

    localparam int D   = 2;
    localparam int GAP = 8;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        upButton = 1'b0;
    logic        downButton = 1'b0;
    logic        leftButton = 1'b0;
    logic        rightButton = 1'b0;
    logic        centerButton = 1'b0;
    logic [17:0] board;
    logic [3:0]  cursor;
    logic        turn;
    logic        moveValid;
    logic        moveReject;
    logic [1:0]  winner;
    logic        gameOver;

    move_controller #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .resetN(resetN),
        .upButton(upButton), .downButton(downButton),
        .leftButton(leftButton), .rightButton(rightButton),
        .centerButton(centerButton),
        .board(board), .cursor(cursor), .turn(turn),
        .moveValid(moveValid), .moveReject(moveReject),
        .winner(winner), .gameOver(gameOver)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          kind;
        int          edge_n;
        int          cur;
        logic [17:0] brd;
        int          trn;
        int          win;
    } exp_t;

    exp_t q[$];

    int m_board[9];
    int m_cursor;
    int m_turn;
    int m_winner;

    function automatic logic [17:0] pack_board();
        logic [17:0] b;
        b = '0;
        for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(m_board[i]);
        return b;
    endfunction

    function automatic int eval_result();
        int ln[8][3];
        int full;
        int w;
        for (int r = 0; r < 3; r++) begin
            ln[r][0] = r*3; ln[r][1] = r*3+1; ln[r][2] = r*3+2;
            ln[3+r][0] = r; ln[3+r][1] = r+3; ln[3+r][2] = r+6;
        end
        ln[6][0] = 0; ln[6][1] = 4; ln[6][2] = 8;
        ln[7][0] = 2; ln[7][1] = 4; ln[7][2] = 6;
        w = 0;
        for (int l = 0; l < 8; l++)
            if (m_board[ln[l][0]] != 0 &&
                m_board[ln[l][0]] == m_board[ln[l][1]] &&
                m_board[ln[l][0]] == m_board[ln[l][2]]) w = m_board[ln[l][0]];
        full = 1;
        for (int i = 0; i < 9; i++) if (m_board[i] == 0) full = 0;
        if (w == 0 && full == 1) w = 3;
        return w;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 9; i++) m_board[i] = 0;
        m_cursor = 4;
        m_turn   = 0;
        m_winner = 0;
    endfunction

    // mask bits: 0 center, 1 up, 2 down, 3 left, 4 right
    function automatic void apply_model(input logic [4:0] mask, input int edge_n);
        exp_t e;
        int row;
        int col;
        row = m_cursor / 3;
        col = m_cursor % 3;
        e.kind = 0;
        if (mask[0]) begin
            if (m_winner == 0 && m_board[m_cursor] == 0) begin
                m_board[m_cursor] = m_turn + 1;
                m_turn = 1 - m_turn;
                e.kind = 1;
            end else begin
                e.kind = 2;
            end
        end else if (mask[1]) begin
            m_cursor = ((row + 2) % 3) * 3 + col;
        end else if (mask[2]) begin
            m_cursor = ((row + 1) % 3) * 3 + col;
        end else if (mask[3]) begin
            m_cursor = row * 3 + (col + 2) % 3;
        end else begin
            m_cursor = row * 3 + (col + 1) % 3;
        end
        if (m_winner == 0) m_winner = eval_result();
        e.edge_n = edge_n;
        e.cur    = m_cursor;
        e.brd    = pack_board();
        e.trn    = m_turn;
        e.win    = m_winner;
        q.push_back(e);
    endfunction

    task automatic drive(input logic [4:0] mask);
        centerButton = mask[0];
        upButton     = mask[1];
        downButton   = mask[2];
        leftButton   = mask[3];
        rightButton  = mask[4];
    endtask

    task automatic press(input logic [4:0] mask, input int hold);
        int e;
        @(negedge clk);
        drive(mask);
        e = cyc + 1;
        if (hold >= D && mask != 0) apply_model(mask, e + 2 + D);
        repeat (hold) @(negedge clk);
        drive(5'b0);
        repeat (GAP) @(negedge clk);
    endtask

    task automatic goto_cell(input int target);
        int guard;
        guard = 0;
        while (m_cursor != target && guard < 10) begin
            if (m_cursor / 3 != target / 3) press(5'b00100, 2);
            else press(5'b10000, 2);
            guard++;
        end
    endtask

    task automatic place(input int target);
        goto_cell(target);
        press(5'b00001, 2);
    endtask

    bit mon_en = 0;
    bit pend_w = 0;
    int pend_win;
    logic [3:0] prev_cursor = 4'd4;

    always @(negedge clk) begin
        exp_t x;
        int kind;
        if (mon_en) begin
            if (pend_w) begin
                check("winner", int'(winner), pend_win);
                check("gameOver", int'(gameOver), int'(pend_win != 0));
                pend_w = 0;
            end
            kind = moveValid ? 1 : (moveReject ? 2 : 0);
            if (moveValid || moveReject || cursor != prev_cursor) begin
                if (q.size() == 0) begin
                    check("unexpected_event", 1, 0);
                end else begin
                    x = q.pop_front();
                    check("event_kind", kind, x.kind);
                    check("event_pulse_pair", int'(moveValid && moveReject), 0);
                    check("event_edge", cyc, x.edge_n);
                    check("cursor", int'(cursor), x.cur);
                    check("board", int'(board), int'(x.brd));
                    check("turn", int'(turn), x.trn);
                    pend_w   = 1;
                    pend_win = x.win;
                end
            end
            prev_cursor = cursor;
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || pend_w) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0 || pend_w) begin
            check("drain_timeout", q.size(), 0);
            q.delete();
            pend_w = 0;
        end
    endtask

    task automatic do_reset();
        mon_en = 0;
        drive(5'b0);
        resetN = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        q.delete();
        pend_w = 0;
        prev_cursor = 4'd4;
        resetN = 1'b1;
        mon_en = 1;
    endtask

    initial begin
        model_reset();
        do_reset();
        repeat (20) @(negedge clk);
        check("rst_board", int'(board), 0);
        check("rst_cursor", int'(cursor), 4);
        check("rst_turn", int'(turn), 0);
        check("rst_winner", int'(winner), 0);
        check("rst_gameOver", int'(gameOver), 0);
        check("rst_pulses", int'({moveValid, moveReject}), 0);

        // Glitch shorter than the debounce window, then a real press
        press(5'b00001, 1);
        press(5'b00001, 10);
        press(5'b00001, 3);
        drain();
        check("after_first_x", int'(board[9:8]), 1);

        // Cursor wrap in column and row, simultaneous up+right
        press(5'b00010, 2);
        press(5'b00010, 2);
        drain();
        check("wrap_up", int'(cursor), 7);
        do_reset();
        press(5'b01000, 2);
        press(5'b01000, 2);
        press(5'b10010, 2);
        drain();
        check("wrap_left_upright", int'(cursor), 2);

        // X wins on the top row
        do_reset();
        place(0); place(3); place(1); place(4); place(2);
        place(8);
        drain();
        check("win_x", int'(winner), 1);
        check("win_board8", int'(board[17:16]), 0);

        // Draw sequence
        do_reset();
        place(0); place(1); place(2); place(4); place(3);
        place(5); place(7); place(6); place(8);
        drain();
        check("draw", int'(winner), 3);

        // Asynchronous reset mid-debounce, button held through release
        @(negedge clk);
        centerButton = 1'b1;
        @(negedge clk);
        mon_en = 0;
        #2 resetN = 1'b0;
        #1;
        check("arst_board", int'(board), 0);
        check("arst_cursor", int'(cursor), 4);
        check("arst_turn", int'(turn), 0);
        check("arst_winner", int'({winner, gameOver}), 0);
        check("arst_pulses", int'({moveValid, moveReject}), 0);
        @(negedge clk);
        model_reset();
        q.delete();
        pend_w = 0;
        prev_cursor = 4'd4;
        resetN = 1'b1;
        mon_en = 1;
        apply_model(5'b00001, cyc + 1 + 2 + D);
        repeat (5) @(negedge clk);
        centerButton = 1'b0;
        repeat (GAP) @(negedge clk);
        drain();

        // Randomized play against the model
        do_reset();
        for (int i = 0; i < 60; i++) begin
            logic [4:0] m;
            if ($urandom_range(0, 1) == 1) m = 5'(1 << $urandom_range(0, 4));
            else m = 5'($urandom_range(1, 31));
            press(m, $urandom_range(1, 4));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=1 expected=0");
        $fatal(1, "timeout");
    end

endmodule
